compute_scheduler: RTL and testbench

Sequences the MAC datapath once A and B buffers are loaded. Walks C = A x B in row-major order and drives buffer read addresses, MAC clear/enable and C-buffer writes. Sits between the top-level controller (start/done) and the A/B/C buffers plus the MAC unit.

---
 rtl/compute_scheduler_pkg.sv | 23 ++
 rtl/compute_scheduler_delay_line.sv | 27 ++
 rtl/compute_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_compute_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compute_scheduler_pkg.sv
// Shared definitions for the compute scheduler: FSM state encoding and the
// bit layout of the issue tag carried down the read-latency delay line.
package compute_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } sched_state_t;

    // issue tag layout: {caddr, last, first, valid}
    localparam int TAG_VALID = 0;
    localparam int TAG_FIRST = 1;
    localparam int TAG_LAST  = 2;
    localparam int TAG_CADDR = 3;

    function automatic int tag_width(input int addr_w);
        return addr_w + TAG_CADDR;
    endfunction

endpackage

// File: rtl/compute_scheduler_delay_line.sv
// Tag shift register that matches the A/B buffer read latency; hold freezes
// every stage so pending tags resume unchanged.
module sched_delay_line #(
    parameter int W     = 11,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
        end else if (!hold) begin
            stage[0] <= din;
            for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/compute_scheduler.sv
// Walks C = A x B in row-major order, driving A/B read addresses, MAC control
// and C writes. Optional stall input is enabled with the STALL_EN macro.
//
// state | meaning
// IDLE  | waiting for start, dims captured on start
// INIT  | clear loop indices, reject empty multiplies
// RUN   | one (i,j,k) issue per cycle, k innermost
// DRAIN | let the last tags leave the delay line and accumulator
// DONE  | one-cycle done pulse
module compute_scheduler
    import compute_scheduler_pkg::*;
#(
    parameter int n      = 4,
    parameter int m      = 8,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
`ifdef STALL_EN
    input  logic         stall,
`endif
    input  logic         start,
    input  logic [n-1:0] dim0,
    input  logic [n-1:0] dim1,
    input  logic [n-1:0] dim2,
    output logic [m-1:0] aadrr,
    output logic [m-1:0] badrr,
    output logic         mac_clr,
    output logic         mac_en,
    output logic         cbufwrite,
    output logic [m-1:0] cadrw,
    output logic         busy,
    output logic         done
);

    localparam int PW = 2 * n;
    localparam int TW = tag_width(m);
    localparam int DW = $clog2(RD_LAT + 2);
    localparam logic [n-1:0]  ONE_N      = {{(n-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DRAIN_ONE  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(RD_LAT);

    sched_state_t  state;
    logic [n-1:0]  d0, d1, d2;
    logic [n-1:0]  i, j, k;
    logic [DW-1:0] drain_cnt;
    logic          k_last, j_last, i_last;
    logic [PW-1:0] a_lin, b_lin, c_lin;
    logic [TW-1:0] tag_in, tag_out;
    logic          hold;
    logic          cbuf_q;

`ifdef STALL_EN
    assign hold = stall && (state == S_RUN || state == S_DRAIN);
`else
    assign hold = 1'b0;
`endif

    assign k_last = (k == d1 - ONE_N);
    assign j_last = (j == d2 - ONE_N);
    assign i_last = (i == d0 - ONE_N);

    assign a_lin = PW'(i) * PW'(d1) + PW'(k);
    assign b_lin = PW'(k) * PW'(d2) + PW'(j);
    assign c_lin = PW'(i) * PW'(d2) + PW'(j);

    always_comb begin
        tag_in = '0;
        if (state == S_RUN) begin
            tag_in[TAG_VALID]      = 1'b1;
            tag_in[TAG_FIRST]      = (k == '0);
            tag_in[TAG_LAST]       = k_last;
            tag_in[TAG_CADDR +: m] = m'(c_lin);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            d0        <= '0;
            d1        <= '0;
            d2        <= '0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            drain_cnt <= '0;
            aadrr     <= '0;
            badrr     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        d0    <= dim0;
                        d1    <= dim1;
                        d2    <= dim2;
                        busy  <= 1'b1;
                        state <= S_INIT;
                    end
                end
                S_INIT: begin
                    i <= '0;
                    j <= '0;
                    k <= '0;
                    // empty multiply: a single drain cycle, nothing issued
                    if (d0 == '0 || d1 == '0 || d2 == '0) begin
                        drain_cnt <= '0;
                        state     <= S_DRAIN;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!hold) begin
                        aadrr <= m'(a_lin);
                        badrr <= m'(b_lin);
                        if (k_last) begin
                            k <= '0;
                            if (j_last) begin
                                j <= '0;
                                if (i_last) begin
                                    drain_cnt <= DRAIN_LOAD;
                                    state     <= S_DRAIN;
                                end else begin
                                    i <= i + ONE_N;
                                end
                            end else begin
                                j <= j + ONE_N;
                            end
                        end else begin
                            k <= k + ONE_N;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!hold) begin
                        if (drain_cnt == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            drain_cnt <= drain_cnt - DRAIN_ONE;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    sched_delay_line #(
        .W     (TW),
        .DEPTH (RD_LAT)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .hold (hold),
        .din  (tag_in),
        .dout (tag_out)
    );

    // write is registered behind the accumulator update of the last product
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cbuf_q <= 1'b0;
            cadrw  <= '0;
        end else if (!hold) begin
            cbuf_q <= tag_out[TAG_VALID] & tag_out[TAG_LAST];
            if (tag_out[TAG_VALID] && tag_out[TAG_LAST]) begin
                cadrw <= tag_out[TAG_CADDR +: m];
            end
        end
    end

    assign mac_en    = tag_out[TAG_VALID] & ~hold;
    assign mac_clr   = tag_out[TAG_VALID] & tag_out[TAG_FIRST] & ~hold;
    assign cbufwrite = cbuf_q & ~hold;

endmodule

// File: tb/tb_compute_scheduler.sv
// Directed bench for compute_scheduler: per-scenario tasks with hand-computed
// address, MAC-control, write and done-timing expectations.
module tb_compute_scheduler;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic [3:0] dim0  = '0;
    logic [3:0] dim1  = '0;
    logic [3:0] dim2  = '0;
    logic [7:0] aadrr, badrr, cadrw;
    logic       mac_clr, mac_en, cbufwrite, busy, done;

    int checks   = 0;
    int failures = 0;

    logic       clr_q [$];
    logic [7:0] a_q [$];
    logic [7:0] b_q [$];
    logic [7:0] w_q [$];
    int         done_edge;
    int         busy_cycles;

    always #5 clk = ~clk;

    compute_scheduler #(
        .n      (4),
        .m      (8),
        .RD_LAT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef STALL_EN
        .stall     (stall),
`endif
        .start     (start),
        .dim0      (dim0),
        .dim1      (dim1),
        .dim2      (dim2),
        .aadrr     (aadrr),
        .badrr     (badrr),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .cbufwrite (cbufwrite),
        .cadrw     (cadrw),
        .busy      (busy),
        .done      (done)
    );

    // Start sampled at edge 0; cycle e is the cycle beginning at edge e.
    // Inputs change 1ns after a rising edge, outputs are sampled on the falling edge.
    task automatic run_op(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                          input int pulse_at, input int stall_at, input int stall_len,
                          input int abort_at, input int budget);
        int e;
        clr_q.delete(); a_q.delete(); b_q.delete(); w_q.delete();
        done_edge   = -1;
        busy_cycles = 0;
        @(posedge clk); #1;
        dim0 = d0; dim1 = d1; dim2 = d2; start = 1'b1;
        @(posedge clk); #1;
        e = 0;
        start = 1'b0;
        dim0 = 4'd15; dim1 = 4'd15; dim2 = 4'd15;
        stall = (e >= stall_at && e < stall_at + stall_len);
        while (1) begin
            @(negedge clk);
            if (mac_en) begin
                clr_q.push_back(mac_clr);
                a_q.push_back(aadrr);
                b_q.push_back(badrr);
            end
            if (cbufwrite) w_q.push_back(cadrw);
            if (busy) busy_cycles++;
            if (done) begin
                done_edge = e;
                break;
            end
            if (e == abort_at || e >= budget) break;
            @(posedge clk); #1;
            e++;
            start = (e == pulse_at);
            stall = (e >= stall_at && e < stall_at + stall_len);
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        #3;
        checks++;
        if ({mac_en, mac_clr, cbufwrite, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000", {mac_en, mac_clr, cbufwrite, busy, done});
        end
        checks++;
        if ({aadrr, badrr, cadrw} !== 24'h0) begin
            failures++;
            $display("FAIL reset_addr: got %h expected 000000", {aadrr, badrr, cadrw});
        end
        start = 1'b0;
        #20 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_2x2x2();
        int exp_a [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
        int exp_b [8] = '{0, 2, 1, 3, 0, 2, 1, 3};
        run_op(4'd2, 4'd2, 4'd2, -1, -1, 0, -1, 60);
        checks++;
        if (a_q.size() != 8) begin
            failures++;
            $display("FAIL 2x2x2 mac_en_count: got %0d expected 8", a_q.size());
        end
        for (int x = 0; x < 8; x++) begin
            checks++;
            if (x >= a_q.size()) begin
                failures++;
                $display("FAIL 2x2x2 issue%0d: got none expected a=%0d b=%0d", x, exp_a[x], exp_b[x]);
            end else if (int'(a_q[x]) != exp_a[x] || int'(b_q[x]) != exp_b[x]
                         || clr_q[x] !== (x % 2 == 0)) begin
                failures++;
                $display("FAIL 2x2x2 issue%0d: got a=%0d b=%0d clr=%b expected a=%0d b=%0d clr=%b",
                         x, a_q[x], b_q[x], clr_q[x], exp_a[x], exp_b[x], (x % 2 == 0));
            end
        end
        checks++;
        if (w_q.size() != 4) begin
            failures++;
            $display("FAIL 2x2x2 write_count: got %0d expected 4", w_q.size());
        end
        for (int x = 0; x < 4; x++) begin
            checks++;
            if (x >= w_q.size() || int'(w_q[x]) != x) begin
                failures++;
                $display("FAIL 2x2x2 cadrw%0d: got %0d expected %0d", x,
                         (x < w_q.size()) ? int'(w_q[x]) : -1, x);
            end
        end
        checks++;
        if (done_edge != 11) begin
            failures++;
            $display("FAIL 2x2x2 done_edge: got %0d expected 11", done_edge);
        end
        checks++;
        if (busy_cycles != 11) begin
            failures++;
            $display("FAIL 2x2x2 busy_cycles: got %0d expected 11", busy_cycles);
        end
    endtask

    task automatic test_1x1x1();
        run_op(4'd1, 4'd1, 4'd1, -1, -1, 0, -1, 30);
        checks++;
        if (a_q.size() != 1 || a_q[0] !== 8'd0 || b_q[0] !== 8'd0 || clr_q[0] !== 1'b1) begin
            failures++;
            $display("FAIL 1x1x1 issue: got count=%0d expected 1 issue a=0 b=0 clr=1", a_q.size());
        end
        checks++;
        if (w_q.size() != 1 || w_q[0] !== 8'd0) begin
            failures++;
            $display("FAIL 1x1x1 write: got count=%0d expected 1 write at cadrw 0", w_q.size());
        end
        checks++;
        if (done_edge != 4) begin
            failures++;
            $display("FAIL 1x1x1 done_edge: got %0d expected 4", done_edge);
        end
    endtask

    task automatic test_zero_dim();
        run_op(4'd3, 4'd0, 4'd3, -1, -1, 0, -1, 30);
        checks++;
        if (a_q.size() != 0 || w_q.size() != 0) begin
            failures++;
            $display("FAIL zero_dim activity: got mac_en=%0d writes=%0d expected 0 0", a_q.size(), w_q.size());
        end
        checks++;
        if (done_edge != 2) begin
            failures++;
            $display("FAIL zero_dim done_edge: got %0d expected 2", done_edge);
        end
        checks++;
        if (busy_cycles != 2) begin
            failures++;
            $display("FAIL zero_dim busy_cycles: got %0d expected 2", busy_cycles);
        end
    endtask

    task automatic test_restart_ignored();
        int exp_b [4] = '{1, 3, 5, 7};
        run_op(4'd3, 4'd4, 4'd2, 10, -1, 0, -1, 80);
        checks++;
        if (a_q.size() != 24) begin
            failures++;
            $display("FAIL 3x4x2 mac_en_count: got %0d expected 24", a_q.size());
        end
        for (int x = 0; x < 4; x++) begin
            checks++;
            if (a_q.size() < 8 || int'(b_q[x+4]) != exp_b[x]) begin
                failures++;
                $display("FAIL 3x4x2 badrr_i0j1_k%0d: got %0d expected %0d", x,
                         (a_q.size() >= 8) ? int'(b_q[x+4]) : -1, exp_b[x]);
            end
        end
        checks++;
        if (w_q.size() != 6) begin
            failures++;
            $display("FAIL 3x4x2 write_count: got %0d expected 6", w_q.size());
        end
        for (int x = 0; x < 6; x++) begin
            checks++;
            if (x >= w_q.size() || int'(w_q[x]) != x) begin
                failures++;
                $display("FAIL 3x4x2 cadrw%0d: got %0d expected %0d", x,
                         (x < w_q.size()) ? int'(w_q[x]) : -1, x);
            end
        end
        checks++;
        if (done_edge != 27) begin
            failures++;
            $display("FAIL 3x4x2 done_edge: got %0d expected 27", done_edge);
        end
    endtask

    task automatic test_reset_mid_run();
        int extra;
        run_op(4'd2, 4'd2, 4'd2, -1, -1, 0, 5, 60);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({mac_en, mac_clr, cbufwrite, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL midrst_ctrl: got %b expected 00000", {mac_en, mac_clr, cbufwrite, busy, done});
        end
        checks++;
        if ({aadrr, badrr, cadrw} !== 24'h0) begin
            failures++;
            $display("FAIL midrst_addr: got %h expected 000000", {aadrr, badrr, cadrw});
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (cbufwrite || mac_en || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL midrst_quiet: got %0d active cycles expected 0", extra);
        end
        run_op(4'd2, 4'd2, 4'd2, -1, -1, 0, -1, 60);
        checks++;
        if (a_q.size() != 8 || a_q[0] !== 8'd0 || b_q[0] !== 8'd0 || clr_q[0] !== 1'b1) begin
            failures++;
            $display("FAIL midrst_rerun_first: got count=%0d expected 8 issues starting a=0 b=0 clr=1", a_q.size());
        end
        checks++;
        if (w_q.size() != 4 || w_q[0] !== 8'd0 || w_q[3] !== 8'd3) begin
            failures++;
            $display("FAIL midrst_rerun_writes: got count=%0d expected 4 writes 0..3", w_q.size());
        end
        checks++;
        if (done_edge != 11) begin
            failures++;
            $display("FAIL midrst_rerun_done: got %0d expected 11", done_edge);
        end
    endtask

`ifdef STALL_EN
    task automatic test_stall();
        int exp_a [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
        int exp_b [8] = '{0, 2, 1, 3, 0, 2, 1, 3};
        run_op(4'd2, 4'd2, 4'd2, -1, 4, 3, -1, 60);
        checks++;
        if (a_q.size() != 8) begin
            failures++;
            $display("FAIL stall mac_en_count: got %0d expected 8", a_q.size());
        end
        for (int x = 0; x < 8; x++) begin
            checks++;
            if (x >= a_q.size() || int'(a_q[x]) != exp_a[x] || int'(b_q[x]) != exp_b[x]
                || clr_q[x] !== (x % 2 == 0)) begin
                failures++;
                $display("FAIL stall issue%0d: got a=%0d b=%0d expected a=%0d b=%0d", x,
                         (x < a_q.size()) ? int'(a_q[x]) : -1, (x < b_q.size()) ? int'(b_q[x]) : -1,
                         exp_a[x], exp_b[x]);
            end
        end
        for (int x = 0; x < 4; x++) begin
            checks++;
            if (w_q.size() != 4 || int'(w_q[x]) != x) begin
                failures++;
                $display("FAIL stall cadrw%0d: got count=%0d expected 4 writes 0..3", x, w_q.size());
            end
        end
        checks++;
        if (done_edge != 14) begin
            failures++;
            $display("FAIL stall done_edge: got %0d expected 14", done_edge);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_2x2x2();
        test_1x1x1();
        test_zero_dim();
        test_restart_ignored();
        test_reset_mid_run();
`ifdef STALL_EN
        test_stall();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
